alu_result_serializer: RTL

- Downstream stage of the ALU/accumulator datapath.
- Captures the 16-bit accumulator result word (sign-extension byte in [15:8], accumulated byte in [7:0]) on a capture strobe and buffers it in a small FIFO.
- Emits each word as two bytes on a valid/ready byte stream, MSB first, for the host/debug link.
- Flags overflow when results arrive faster than the link drains them.

---
 rtl/alu_pkg.sv | 16 +
 rtl/result_fifo.sv | 73 +++++++
 rtl/alu_result_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result serializer.
//   ser_state_e : byte serializer states (IDLE, HI, LO)
//   BYTE_W      : width of one stream byte
//   RESULT_W    : width of one accumulator result word
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } ser_state_e;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned RESULT_W = 16;

endpackage

// File: rtl/result_fifo.sv
// Synchronous-write FIFO with a registered occupancy count and show-ahead read data.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers and count only)
//   push, wdata  : write wdata at the edge (caller must not push when full)
//   pop, rdata   : rdata is the head word; pop advances it at the edge (caller must not
//                  pop when empty)
//   full, empty  : decoded from the registered count
//   count        : number of stored words
module result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a word is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers captured 16-bit accumulator results and streams each as two bytes, high first.
//   clk, rst_n            : clock, asynchronous active-low reset
//   datain, capture       : result word and its capture strobe
//   out_data/valid/ready  : byte stream handshake; out_last marks the low byte
//   fifo_count, full      : words waiting behind the shifter
//   overflow, clear_ovf   : sticky dropped-capture flag and its clear
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RESULT_W-1:0] datain,
    input  logic                capture,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [CNT_W-1:0]    fifo_count,
    output logic                full,
    output logic                overflow,
    input  logic                clear_ovf
);

    ser_state_e          state_q, state_d;
    logic [RESULT_W-1:0] shift_q, shift_d;
    logic                ovf_q, ovf_d;

    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [RESULT_W-1:0] fifo_rdata;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RESULT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (datain),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // full is the registered-count view, so a pop in the same cycle does not make room.
    assign push = capture && !full;

    always_comb begin
        ovf_d = ovf_q;
        if (capture && full) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Outputs depend only on state and shifter, so out_ready never reaches out_valid.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = HI;
                end
            end
            HI: begin
                out_valid = 1'b1;
                out_data  = shift_q[RESULT_W-1:BYTE_W];
                if (out_ready) begin
                    state_d = LO;
                end
            end
            LO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = shift_q[BYTE_W-1:0];
                if (out_ready) begin
                    // Reload straight from the FIFO so consecutive words have no bubble.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;

endmodule
